sub_pipe: RTL and testbench

- Two-stage pipelined W-bit mantissa subtractor for the floating-point divider datapath. It computes D = A - B - Bin using a borrow-lookahead tree.
- It is the inverse-direction counterpart of the team's adder and incrementer cells. The divider's partial-remainder and exponent-difference paths use it.
- Elastic valid/ready pipeline: the block stalls without losing data.

---
 rtl/sub_pipe_pkg.sv | 21 ++
 rtl/sub_pipe_bl_group4.sv | 20 ++
 rtl/sub_pipe.sv | 126 ++++++++++++
 tb/tb_sub_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sub_pipe_pkg.sv
// Shared constants and the two-input (g,p) prefix combine cell for sub_pipe.
package sub_pipe_pkg;

  localparam int W_DEF    = 24;
  localparam int GRP      = 4;
  localparam int NGRP_DEF = W_DEF / GRP;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Borrow semantics match carry semantics: hi generates, or hi propagates lo.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/sub_pipe_bl_group4.sv
// 4-bit borrow-lookahead group: group generate/propagate and internal borrows.
module bl_group4 (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic       g_grp,
  output logic       p_grp,
  output logic [3:1] c
);

  // Fully expanded lookahead; c[i] is the borrow into bit i of the group.
  always_comb begin
    c[1]  = g[0] | (p[0] & cin);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    g_grp = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
  end

endmodule

// File: rtl/sub_pipe.sv
// Two-stage elastic mantissa subtractor: diff = (a - b - bin) mod 2^W.
// S1 registers bitwise g/p/h and group G/P; S2 resolves borrows and registers the result.
module sub_pipe
  import sub_pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         zero
);

  localparam int NG = W / GRP;

  logic         s1_v_q, s2_v_q;
  logic [W-1:0] s1_g_q, s1_p_q, s1_h_q;
  logic [NG-1:0] s1_gg_q, s1_gp_q;
  logic         s1_bin_q;
  logic [W-1:0] diff_q, diff_d;
  logic         bout_q, bout_d, zero_q, zero_d;

  logic         s1_adv, s2_adv;
  logic [W-1:0] g_d, p_d, h_d;
  logic [NG-1:0] gg_d, gp_d;
  logic [3*NG-1:0] c_s1_unused;
  logic [2*NG-1:0] gp_s2_unused;
  logic [NG:0]  gbin;
  logic [W-1:0] c_s2;

  // Back-pressure travels backwards combinationally; in_valid never feeds in_ready.
  assign s2_adv   = ~s2_v_q | out_ready;
  assign s1_adv   = ~s1_v_q | s2_adv;
  assign in_ready = s1_adv;

  assign g_d = ~a & b;
  assign p_d = ~(a ^ b);
  assign h_d = a ^ b;

  for (genvar gi = 0; gi < NG; gi++) begin : g_s1_grp
    bl_group4 u_gp (
      .g    (g_d[GRP*gi +: GRP]),
      .p    (p_d[GRP*gi +: GRP]),
      .cin  (1'b0),
      .g_grp(gg_d[gi]),
      .p_grp(gp_d[gi]),
      .c    (c_s1_unused[3*gi +: 3])
    );
  end

  // Prefix-combine group (G,P) with bin to form each group's borrow-in.
  always_comb begin
    gp_t acc;
    acc  = '{g: s1_bin_q, p: 1'b0};
    gbin = '0;
    for (int k = 0; k < NG; k++) begin
      gbin[k] = acc.g;
      acc     = gp_combine('{g: s1_gg_q[k], p: s1_gp_q[k]}, acc);
    end
    gbin[NG] = acc.g;
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_s2_grp
    assign c_s2[GRP*gi] = gbin[gi];
    bl_group4 u_res (
      .g    (s1_g_q[GRP*gi +: GRP]),
      .p    (s1_p_q[GRP*gi +: GRP]),
      .cin  (gbin[gi]),
      .g_grp(gp_s2_unused[2*gi]),
      .p_grp(gp_s2_unused[2*gi+1]),
      .c    (c_s2[GRP*gi+1 +: 3])
    );
  end

  assign diff_d = s1_h_q ^ c_s2;
  assign bout_d = gbin[NG];
  assign zero_d = ~|diff_d;

  // Stage 1: capture per-bit and per-group lookahead terms when the stage advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_g_q   <= g_d;
        s1_p_q   <= p_d;
        s1_h_q   <= h_d;
        s1_gg_q  <= gg_d;
        s1_gp_q  <= gp_d;
        s1_bin_q <= bin;
      end
    end
  end

  // Stage 2: register the resolved result; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        diff_q <= diff_d;
        bout_q <= bout_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_sub_pipe.sv
// Scoreboard bench for sub_pipe: driver pushes expected results, monitor pops on output handshakes.
module tb_sub_pipe;
  localparam int W = 24;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout, zero;
  logic [W-1:0] a, b, diff;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t pend;
  bit   hold_v = 1'b0;
  exp_t hold_val;

  always #5 clk = ~clk;

  sub_pipe #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] t;
    exp_t e;
    t    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    e.d  = t[W-1:0];
    e.bo = t[W];
    e.z  = (t[W-1:0] == '0);
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v)
        chk("hold", {5'd0, out_valid, diff, bout, zero}, {5'd0, 1'b1, hold_val});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {6'd0, diff, bout, zero}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("result", {6'd0, diff, bout, zero}, {6'd0, e});
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {diff, bout, zero};
      if (in_valid && in_ready) q.push_back(pend);
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the op is accepted.
  task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                         input logic [W-1:0] ed, input logic eb, input logic ez);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    bin      = bi;
    pend     = '{d: ed, bo: eb, z: ez};
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  initial begin
    bit held;
    held      = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 24'h000005;
    b         = 24'h000003;
    bin       = 1'b0;
    out_ready = 1'b1;
    pend      = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {8'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic op with a latency probe.
    send_op(24'h000005, 24'h000003, 1'b0, 24'h000002, 1'b0, 1'b0);
    chk("lat_s1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_s2", {31'd0, out_valid}, 32'd1);
    chk("lat_diff", {8'd0, diff}, 32'h000002);
    wait_drain();

    // Wrap-around, exact zero and full-length borrow chain.
    send_op(24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1, 1'b0);
    send_op(24'h800000, 24'h7FFFFF, 1'b1, 24'h000000, 1'b0, 1'b1);
    send_op(24'h000000, 24'h000000, 1'b1, 24'hFFFFFF, 1'b1, 1'b0);
    send_op(24'hFFFFFF, 24'h000000, 1'b0, 24'hFFFFFF, 1'b0, 1'b0);
    send_op(24'h123456, 24'h123456, 1'b0, 24'h000000, 1'b0, 1'b1);
    send_op(24'h000000, 24'hFFFFFF, 1'b1, 24'h000000, 1'b1, 1'b1);
    send_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 1'b1, 1'b0);
    send_op(24'h0F0F0F, 24'h00F0F1, 1'b0, 24'h0E1E1E, 1'b0, 1'b0);
    wait_drain();

    // Back-pressure: four back-to-back ops, consumer stalled at first.
    out_ready = 1'b0;
    fork
      begin
        send_op(24'd10, 24'd1, 1'b0, 24'd9,  1'b0, 1'b0);
        send_op(24'd20, 24'd2, 1'b0, 24'd18, 1'b0, 1'b0);
        send_op(24'd30, 24'd3, 1'b0, 24'd27, 1'b0, 1'b0);
        send_op(24'd40, 24'd4, 1'b0, 24'd36, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_diff", {8'd0, diff}, 32'd9);
        chk("stall_occupancy", q.size(), 32'd2);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Random traffic with mid-stream resets.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (i % 2500 == 1202) chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      if (i % 2500 == 1200) rst_n = 1'b0;
      else if (i % 2500 == 1202) rst_n = 1'b1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!held) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = W'($urandom);
        b        = W'($urandom);
        if ($urandom_range(0, 15) == 0) b = a;
        bin      = 1'($urandom_range(0, 1));
        pend     = model(a, b, bin);
      end
      @(negedge clk);
      held = in_valid && !in_ready && rst_n;
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
